// File: rtl/seg_display_driver.sv
// Multi-digit seven-segment driver: captures a value on load, converts it to BCD with a
// sequential double-dabble engine (decimal) or splits it into nibbles (hex), and updates
// all active-low digit patterns together in the COMMIT cycle.
module seg_display_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_W-1:0]       value,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int unsigned HEX_W   = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W   = 7 * NUM_DIGITS;
  localparam int unsigned EXT_W   = (DATA_W > HEX_W) ? DATA_W : HEX_W;
  localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DEC_MAX = 32'((10 ** NUM_DIGITS) - 1);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   val_q;
  logic [DATA_W-1:0]   bin_q;
  logic [HEX_W-1:0]    bcd_q;
  logic                hex_q;
  logic                blank_q;

  logic                accept_c;
  logic [HEX_W-1:0]    bcd_adj_c;
  logic [EXT_W-1:0]    val_ext_c;
  logic [HEX_W-1:0]    digits_c;
  logic                ovf_c;
  logic                seen_c;
  logic [3:0]          nib_c;
  logic [SEG_W-1:0]    seg_c;

  // Active-low gfedcba glyph for one nibble
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign accept_c = (state_q == IDLE) && load;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: decimal goes through DATA_W shift cycles, hex commits directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = hex_mode ? COMMIT : SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction applied to every BCD nibble before each shift
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj_c[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Digit source selection and overflow detection for the captured value
  always_comb begin
    val_ext_c = EXT_W'(val_q);
    digits_c  = hex_q ? val_ext_c[HEX_W-1:0] : bcd_q;
    ovf_c     = hex_q ? (|(val_ext_c >> HEX_W)) : (32'(val_q) > DEC_MAX);
  end

  // Glyph generation with leading-zero blanking scanned from the top digit down
  always_comb begin
    seg_c  = '0;
    seen_c = 1'b0;
    nib_c  = 4'd0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      nib_c = digits_c[4*k +: 4];
      if ((nib_c != 4'd0) || (k == 0)) seen_c = 1'b1;
      if (ovf_c)                     seg_c[7*k +: 7] = SEG_DASH;
      else if (blank_q && !seen_c)   seg_c[7*k +: 7] = SEG_BLANK;
      else                           seg_c[7*k +: 7] = glyph(nib_c);
    end
  end

  // Capture, double-dabble shifting and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      seg_out  <= {NUM_DIGITS{SEG_ZERO}};
      cnt_q    <= '0;
      val_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      hex_q    <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == COMMIT);
      if (accept_c) begin
        val_q   <= value;
        bin_q   <= value;
        hex_q   <= hex_mode;
        blank_q <= blank_lz;
        bcd_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
        bcd_q <= {bcd_adj_c[HEX_W-2:0], bin_q[DATA_W-1]};
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == COMMIT) begin
        seg_out  <= seg_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver (NUM_DIGITS=4, DATA_W=14) with hand-computed glyphs.
module tb_seg_display_driver;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [13:0] value;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [27:0] seg_out;

  int checks = 0;
  int errors = 0;

  seg_display_driver #(.NUM_DIGITS(4), .DATA_W(14)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .value    (value),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .seg_out  (seg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one edge, scramble inputs afterwards, then track busy/done until idle
  task automatic run_load(input string tag, input logic [13:0] v, input logic hx, input logic bl,
                          input int exp_done, input logic exp_ovf, input logic [27:0] exp_seg);
    int cyc;
    int done_at;
    int busy_cnt;
    value    = v;
    hex_mode = hx;
    blank_lz = bl;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    value    = ~v;
    hex_mode = ~hx;
    blank_lz = ~bl;
    cyc      = 1;
    done_at  = 0;
    busy_cnt = 0;
    while (busy && cyc < 100) begin
      busy_cnt++;
      if (done && done_at == 0) done_at = cyc;
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_done));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_seg"}, 32'(seg_out), 32'(exp_seg));
  endtask

  initial begin
    int done_seen;
    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_seg", 32'(seg_out), 32'({G0, G0, G0, G0}));

    run_load("dec1234",  14'd1234,  1'b0, 1'b0, 15, 1'b0, {G1, G2, G3, G4});
    run_load("dec42_lz", 14'd42,    1'b0, 1'b1, 15, 1'b0, {BL, BL, G4, G2});
    run_load("dec0_lz",  14'd0,     1'b0, 1'b1, 15, 1'b0, {BL, BL, BL, G0});
    run_load("hex3AF",   14'h3AF,   1'b1, 1'b0, 1,  1'b0, {G0, G3, GA, GF});
    run_load("hex3BCD",  14'h3BCD,  1'b1, 1'b0, 1,  1'b0, {G3, GB, GC, GD});
    run_load("hex3E6",   14'h3E6,   1'b1, 1'b1, 1,  1'b0, {BL, G3, GE, G6});
    run_load("hex00A",   14'h00A,   1'b1, 1'b1, 1,  1'b0, {BL, BL, BL, GA});
    run_load("dec1005",  14'd1005,  1'b0, 1'b1, 15, 1'b0, {G1, G0, G0, G5});
    run_load("dec10000", 14'd10000, 1'b0, 1'b1, 15, 1'b1, {DS, DS, DS, DS});
    run_load("dec16383", 14'd16383, 1'b0, 1'b0, 15, 1'b1, {DS, DS, DS, DS});
    run_load("dec9999",  14'd9999,  1'b0, 1'b0, 15, 1'b0, {G9, G9, G9, G9});
    run_load("dec7080",  14'd7080,  1'b0, 1'b0, 15, 1'b0, {G7, G0, G8, G0});

    // Abort: load 1234, ignored load at cycle 5, reset at cycle 8
    done_seen = 0;
    value     = 14'd1234;
    hex_mode  = 1'b0;
    blank_lz  = 1'b0;
    load      = 1'b1;
    tick();
    load = 1'b0;
    for (int cyc = 1; cyc < 8; cyc++) begin
      if (done) done_seen++;
      if (cyc == 5) begin
        value = 14'd5678;
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    check("abort_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_seg", 32'(seg_out), 32'({G0, G0, G0, G0}));
    for (int i = 0; i < 20; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_seg_held", 32'(seg_out), 32'({G0, G0, G0, G0}));

    run_load("dec5678", 14'd5678, 1'b0, 1'b0, 15, 1'b0, {G5, G6, G7, G8});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
